// File: rtl/l1_wt_cache.sv
// Direct-mapped, write-through, no-write-allocate L1 cache with one 16-bit word per line.
// A single Moore FSM sequences core requests onto the physical-memory request/response port.
module l1_wt_cache #(
  parameter int INDEX_BITS = 3
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [15:0] mem_address,
  input  logic [15:0] mem_wdata,
  input  logic [1:0]  mem_byte_enable,
  output logic        mem_resp,
  output logic [15:0] mem_rdata,
  output logic        pmem_read,
  output logic        pmem_write,
  output logic [15:0] pmem_address,
  output logic [15:0] pmem_wdata,
  output logic [1:0]  pmem_byte_enable,
  input  logic        pmem_resp,
  input  logic [15:0] pmem_rdata
);

  localparam int LINES = 1 << INDEX_BITS;
  localparam int TAG_W = 15 - INDEX_BITS;

  typedef enum logic [1:0] {IDLE, MISS, WRITE, RESP} state_t;

  state_t                  state;
  logic [15:0]             data_arr [LINES];
  logic [TAG_W-1:0]        tag_arr  [LINES];
  logic [LINES-1:0]        valid;

  logic [INDEX_BITS-1:0]   idx_req;
  logic [INDEX_BITS-1:0]   idx_lat;
  logic [TAG_W-1:0]        tag_req;
  logic [TAG_W-1:0]        tag_lat;
  logic                    hit_req;
  logic                    hit_lat;

  function automatic logic [15:0] merge_bytes(input logic [15:0] cur,
                                              input logic [15:0] wdata,
                                              input logic [1:0]  be);
    logic [15:0] res;
    res = cur;
    if (be[0]) res[7:0]  = wdata[7:0];
    if (be[1]) res[15:8] = wdata[15:8];
    return res;
  endfunction

  // Lookup on the live core address (IDLE) and on the latched address (MISS/WRITE).
  assign idx_req = mem_address[INDEX_BITS:1];
  assign tag_req = mem_address[15:INDEX_BITS+1];
  assign idx_lat = pmem_address[INDEX_BITS:1];
  assign tag_lat = pmem_address[15:INDEX_BITS+1];
  assign hit_req = valid[idx_req] && (tag_arr[idx_req] == tag_req);
  assign hit_lat = valid[idx_lat] && (tag_arr[idx_lat] == tag_lat);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state            <= IDLE;
      valid            <= '0;
      mem_resp         <= 1'b0;
      mem_rdata        <= '0;
      pmem_read        <= 1'b0;
      pmem_write       <= 1'b0;
      pmem_address     <= '0;
      pmem_wdata       <= '0;
      pmem_byte_enable <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (mem_write || mem_read) begin
            pmem_address     <= mem_address & 16'hFFFE;
            pmem_wdata       <= mem_wdata;
            pmem_byte_enable <= mem_byte_enable;
            if (mem_write) begin
              pmem_write <= 1'b1;
              state      <= WRITE;
            end else if (hit_req) begin
              mem_rdata <= data_arr[idx_req];
              mem_resp  <= 1'b1;
              state     <= RESP;
            end else begin
              pmem_read <= 1'b1;
              state     <= MISS;
            end
          end
        end
        MISS: begin
          if (pmem_resp) begin
            pmem_read      <= 1'b0;
            valid[idx_lat] <= 1'b1;
            mem_rdata      <= pmem_rdata;
            mem_resp       <= 1'b1;
            state          <= RESP;
          end
        end
        WRITE: begin
          if (pmem_resp) begin
            pmem_write <= 1'b0;
            mem_resp   <= 1'b1;
            state      <= RESP;
          end
        end
        RESP: begin
          mem_resp <= 1'b0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Data and tag arrays carry no reset; the valid bits alone decide hits.
  always_ff @(posedge clk) begin
    if (reset_n && state == MISS && pmem_resp) begin
      data_arr[idx_lat] <= pmem_rdata;
      tag_arr[idx_lat]  <= tag_lat;
    end else if (reset_n && state == WRITE && pmem_resp && hit_lat) begin
      data_arr[idx_lat] <= merge_bytes(data_arr[idx_lat], pmem_wdata, pmem_byte_enable);
    end
  end

endmodule

// File: tb/tb_l1_wt_cache.sv
// Testbench for l1_wt_cache: a behavioural physical memory plus a scoreboard of expected
// read data, exercised by one task per scenario.
module tb_l1_wt_cache;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        mem_read, mem_write;
  logic [15:0] mem_address, mem_wdata;
  logic [1:0]  mem_byte_enable;
  logic        mem_resp;
  logic [15:0] mem_rdata;
  logic        pmem_read, pmem_write;
  logic [15:0] pmem_address, pmem_wdata;
  logic [1:0]  pmem_byte_enable;
  logic        pmem_resp;
  logic [15:0] pmem_rdata;

  int checks = 0;
  int fails  = 0;

  logic [15:0] mem_model [int];
  bit          auto_resp  = 1'b1;
  int          resp_delay = 3;
  int          rd_bursts  = 0;
  int          wr_bursts  = 0;
  int          overlap    = 0;
  logic [15:0] last_waddr, last_wdata;
  logic [1:0]  last_be;
  logic [15:0] exp_q [$];

  always #5 clk = ~clk;

  l1_wt_cache #(.INDEX_BITS(3)) dut (
    .clk(clk), .reset_n(reset_n),
    .mem_read(mem_read), .mem_write(mem_write), .mem_address(mem_address),
    .mem_wdata(mem_wdata), .mem_byte_enable(mem_byte_enable),
    .mem_resp(mem_resp), .mem_rdata(mem_rdata),
    .pmem_read(pmem_read), .pmem_write(pmem_write), .pmem_address(pmem_address),
    .pmem_wdata(pmem_wdata), .pmem_byte_enable(pmem_byte_enable),
    .pmem_resp(pmem_resp), .pmem_rdata(pmem_rdata)
  );

  // Physical memory: answers each request resp_delay cycles after it is raised.
  initial begin
    int          wait_cnt;
    bit          prev_rd, prev_wr;
    int          key;
    logic [15:0] old;
    wait_cnt = 0; prev_rd = 0; prev_wr = 0;
    pmem_resp = 1'b0; pmem_rdata = '0;
    forever begin
      @(negedge clk);
      if (pmem_read && pmem_write) overlap++;
      if (pmem_read && !prev_rd) rd_bursts++;
      if (pmem_write && !prev_wr) wr_bursts++;
      prev_rd = (pmem_read === 1'b1);
      prev_wr = (pmem_write === 1'b1);
      if (auto_resp) begin
        if (pmem_resp) begin
          pmem_resp = 1'b0;
          wait_cnt  = 0;
        end else if (pmem_read || pmem_write) begin
          wait_cnt++;
          if (wait_cnt >= resp_delay) begin
            key = int'(pmem_address[15:1]);
            old = mem_model.exists(key) ? mem_model[key] : 16'h0000;
            pmem_resp = 1'b1;
            if (pmem_read) begin
              pmem_rdata = old;
            end else begin
              last_waddr = pmem_address;
              last_wdata = pmem_wdata;
              last_be    = pmem_byte_enable;
              if (pmem_byte_enable[0]) old[7:0]  = pmem_wdata[7:0];
              if (pmem_byte_enable[1]) old[15:8] = pmem_wdata[15:8];
              mem_model[key] = old;
            end
          end
        end else begin
          wait_cnt = 0;
        end
      end
    end
  end

  task automatic core_op(input bit wr, input logic [15:0] addr, input logic [15:0] wdata,
                         input logic [1:0] be, output logic [15:0] rdata, output int lat,
                         output logic after);
    @(negedge clk);
    mem_read = !wr; mem_write = wr;
    mem_address = addr; mem_wdata = wdata; mem_byte_enable = be;
    lat = 0;
    while (lat < 64) begin
      @(negedge clk);
      lat++;
      if (mem_resp === 1'b1) break;
    end
    rdata = mem_rdata;
    mem_read = 1'b0; mem_write = 1'b0;
    @(negedge clk);
    after = mem_resp;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; mem_read = 0; mem_write = 0;
    mem_address = '0; mem_wdata = '0; mem_byte_enable = '0;
    repeat (3) @(negedge clk);
    checks++;
    if ({mem_resp, mem_rdata, pmem_read, pmem_write, pmem_address, pmem_wdata,
         pmem_byte_enable} !== 52'h0) begin
      fails++;
      $display("FAIL reset_outputs: resp=%b rdata=%h prd=%b pwr=%b paddr=%h pwdata=%h pbe=%b, all must be 0",
               mem_resp, mem_rdata, pmem_read, pmem_write, pmem_address, pmem_wdata, pmem_byte_enable);
    end
    reset_n = 1'b1;
  endtask

  task automatic test_read_miss();
    logic [15:0] rd, exp; int lat; logic aft; int rb0;
    rb0 = rd_bursts; resp_delay = 3;
    exp_q.push_back(16'h1234);
    core_op(0, 16'h0010, 16'h0, 2'b11, rd, lat, aft);
    exp = exp_q.pop_front();
    checks++; if (rd !== exp) begin fails++; $display("FAIL miss_rdata: got %h expected %h", rd, exp); end
    checks++; if (lat != 4) begin fails++; $display("FAIL miss_latency: got %0d expected 4", lat); end
    checks++; if (rd_bursts - rb0 != 1) begin fails++; $display("FAIL miss_bursts: got %0d expected 1", rd_bursts - rb0); end
    checks++; if (aft !== 1'b0) begin fails++; $display("FAIL resp_pulse_width: mem_resp=%b one cycle later, expected 0", aft); end
  endtask

  task automatic test_read_hit();
    logic [15:0] rd, exp; int lat; logic aft; int rb0;
    rb0 = rd_bursts;
    exp_q.push_back(16'h1234);
    core_op(0, 16'h0010, 16'h0, 2'b00, rd, lat, aft);
    exp = exp_q.pop_front();
    checks++; if (rd !== exp) begin fails++; $display("FAIL hit_rdata: got %h expected %h", rd, exp); end
    checks++; if (lat != 1) begin fails++; $display("FAIL hit_latency: got %0d expected 1", lat); end
    checks++; if (rd_bursts != rb0) begin fails++; $display("FAIL hit_no_pmem: got %0d bursts expected 0", rd_bursts - rb0); end
  endtask

  task automatic test_write_partial();
    logic [15:0] rd, exp; int lat; logic aft; int wb0, rb0;
    wb0 = wr_bursts; resp_delay = 2;
    core_op(1, 16'h0010, 16'hABCD, 2'b01, rd, lat, aft);
    checks++; if (lat != 3) begin fails++; $display("FAIL write_latency: got %0d expected 3", lat); end
    checks++; if (wr_bursts - wb0 != 1) begin fails++; $display("FAIL write_bursts: got %0d expected 1", wr_bursts - wb0); end
    checks++;
    if ({last_waddr, last_wdata, last_be} !== {16'h0010, 16'hABCD, 2'b01}) begin
      fails++;
      $display("FAIL write_fields: got addr=%h data=%h be=%b expected 0010 abcd 01", last_waddr, last_wdata, last_be);
    end
    rb0 = rd_bursts;
    exp_q.push_back(16'h12CD);
    core_op(0, 16'h0010, 16'h0, 2'b00, rd, lat, aft);
    exp = exp_q.pop_front();
    checks++; if (rd !== exp) begin fails++; $display("FAIL merged_rdata: got %h expected %h", rd, exp); end
    checks++; if (lat != 1 || rd_bursts != rb0) begin fails++; $display("FAIL merged_hit: latency %0d bursts %0d expected 1 and 0", lat, rd_bursts - rb0); end
  endtask

  task automatic test_evict();
    logic [15:0] rd, exp; int lat; logic aft; int rb0;
    resp_delay = 3; rb0 = rd_bursts;
    exp_q.push_back(16'h5555);
    core_op(0, 16'h0020, 16'h0, 2'b11, rd, lat, aft);
    exp = exp_q.pop_front();
    checks++; if (rd !== exp) begin fails++; $display("FAIL conflict_rdata: got %h expected %h", rd, exp); end
    checks++; if (rd_bursts - rb0 != 1 || lat != 4) begin fails++; $display("FAIL conflict_miss: bursts %0d latency %0d expected 1 and 4", rd_bursts - rb0, lat); end
    rb0 = rd_bursts;
    exp_q.push_back(16'h12CD);
    core_op(0, 16'h0010, 16'h0, 2'b11, rd, lat, aft);
    exp = exp_q.pop_front();
    checks++; if (rd !== exp) begin fails++; $display("FAIL evicted_rdata: got %h expected %h", rd, exp); end
    checks++; if (rd_bursts - rb0 != 1) begin fails++; $display("FAIL evicted_miss: got %0d bursts expected 1", rd_bursts - rb0); end
  endtask

  task automatic test_write_no_mask();
    logic [15:0] rd, exp; int lat; logic aft; int wb0, rb0;
    wb0 = wr_bursts;
    core_op(1, 16'h0010, 16'hFFFF, 2'b00, rd, lat, aft);
    checks++; if (wr_bursts - wb0 != 1 || last_be !== 2'b00 || lat != 4) begin
      fails++; $display("FAIL zero_mask_write: bursts %0d be %b latency %0d expected 1 00 4", wr_bursts - wb0, last_be, lat);
    end
    rb0 = rd_bursts;
    exp_q.push_back(16'h12CD);
    core_op(0, 16'h0010, 16'h0, 2'b11, rd, lat, aft);
    exp = exp_q.pop_front();
    checks++; if (rd !== exp || lat != 1 || rd_bursts != rb0) begin
      fails++; $display("FAIL zero_mask_hit: got %h latency %0d expected %h latency 1", rd, lat, exp);
    end
  endtask

  task automatic test_no_allocate();
    logic [15:0] rd, exp; int lat; logic aft; int wb0, rb0;
    wb0 = wr_bursts;
    core_op(1, 16'h0040, 16'h7777, 2'b11, rd, lat, aft);
    checks++; if (wr_bursts - wb0 != 1 || last_waddr !== 16'h0040) begin
      fails++; $display("FAIL uncached_write: bursts %0d addr %h expected 1 0040", wr_bursts - wb0, last_waddr);
    end
    rb0 = rd_bursts;
    exp_q.push_back(16'h7777);
    core_op(0, 16'h0040, 16'h0, 2'b11, rd, lat, aft);
    exp = exp_q.pop_front();
    checks++; if (rd !== exp) begin fails++; $display("FAIL no_alloc_rdata: got %h expected %h", rd, exp); end
    checks++; if (rd_bursts - rb0 != 1) begin fails++; $display("FAIL no_alloc_miss: got %0d bursts expected 1", rd_bursts - rb0); end
  endtask

  task automatic test_reset_mid_miss();
    logic [15:0] rd, exp; int lat; logic aft; int rb0; logic seen;
    auto_resp = 1'b0;
    @(negedge clk);
    mem_read = 1'b1; mem_address = 16'h0012;
    repeat (2) @(negedge clk);
    checks++; if (pmem_read !== 1'b1) begin fails++; $display("FAIL pending_miss: pmem_read=%b expected 1", pmem_read); end
    reset_n = 1'b0; mem_read = 1'b0;
    @(negedge clk);
    checks++; if (pmem_read !== 1'b0 || mem_rdata !== 16'h0) begin
      fails++; $display("FAIL mid_reset: pmem_read=%b mem_rdata=%h expected 0 0000", pmem_read, mem_rdata);
    end
    reset_n = 1'b1;
    pmem_rdata = 16'hDEAD; pmem_resp = 1'b1;
    @(negedge clk);
    pmem_resp = 1'b0;
    seen = mem_resp;
    repeat (3) begin @(negedge clk); seen = seen | mem_resp; end
    checks++; if (seen !== 1'b0 || pmem_read !== 1'b0) begin
      fails++; $display("FAIL late_resp: mem_resp seen=%b pmem_read=%b expected 0 0", seen, pmem_read);
    end
    auto_resp = 1'b1;
    rb0 = rd_bursts;
    exp_q.push_back(16'h12CD);
    core_op(0, 16'h0010, 16'h0, 2'b11, rd, lat, aft);
    exp = exp_q.pop_front();
    checks++; if (rd !== exp) begin fails++; $display("FAIL post_reset_rdata: got %h expected %h", rd, exp); end
    checks++; if (rd_bursts - rb0 != 1) begin fails++; $display("FAIL post_reset_miss: got %0d bursts expected 1", rd_bursts - rb0); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    mem_model[int'(16'h0010 >> 1)] = 16'h1234;
    mem_model[int'(16'h0020 >> 1)] = 16'h5555;
    test_reset();
    test_read_miss();
    test_read_hit();
    test_write_partial();
    test_evict();
    test_write_no_mask();
    test_no_allocate();
    test_reset_mid_miss();
    checks++; if (overlap != 0) begin fails++; $display("FAIL pmem_exclusive: %0d cycles with both requests, expected 0", overlap); end
    checks++; if (exp_q.size() != 0) begin fails++; $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size()); end
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
